// File: rtl/cmp_issue_ctrl_if.sv
// Request/comparator/response signal bundle for cmp_issue_ctrl.
// master: the issue controller's view. slave: the environment's view.
// The RSP_MISMATCH signal exists only when CMP_ISSUE_CHECK_EN is defined.
interface cmp_issue_ctrl_if #(
  parameter int WIDTH = 16
);
  logic                    REQ_VALID;
  logic                    REQ_READY;
  logic signed [WIDTH-1:0] REQ_A;
  logic signed [WIDTH-1:0] REQ_B;
  logic [1:0]              REQ_FUN;
  logic signed [WIDTH-1:0] CMP_A;
  logic signed [WIDTH-1:0] CMP_B;
  logic [1:0]              CMP_FUN;
  logic                    CMP_Enable;
  logic [1:0]              CMP_OUT;
  logic                    CMP_Flag;
  logic                    RSP_VALID;
  logic                    RSP_READY;
  logic [1:0]              RSP_CODE;
  logic                    RSP_ERR;
`ifdef CMP_ISSUE_CHECK_EN
  logic                    RSP_MISMATCH;
`endif

  modport master (
    input  REQ_VALID, REQ_A, REQ_B, REQ_FUN, CMP_OUT, CMP_Flag, RSP_READY,
`ifdef CMP_ISSUE_CHECK_EN
    output RSP_MISMATCH,
`endif
    output REQ_READY, CMP_A, CMP_B, CMP_FUN, CMP_Enable, RSP_VALID, RSP_CODE, RSP_ERR
  );

  modport slave (
    output REQ_VALID, REQ_A, REQ_B, REQ_FUN, CMP_OUT, CMP_Flag, RSP_READY,
`ifdef CMP_ISSUE_CHECK_EN
    input  RSP_MISMATCH,
`endif
    input  REQ_READY, CMP_A, CMP_B, CMP_FUN, CMP_Enable, RSP_VALID, RSP_CODE, RSP_ERR
  );
endinterface

// File: rtl/cmp_issue_ctrl.sv
// cmp_issue_ctrl: issues one compare request at a time to a registered comparator,
// waits for its flag (bounded by TIMEOUT cycles) and returns the 2-bit result on a
// valid/ready response port.
// Optional build macro CMP_ISSUE_CHECK_EN adds a local signed reference and the
// RSP_MISMATCH response bit.
module cmp_issue_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic         CLK,
  input  logic         RST,
  cmp_issue_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        wait_cnt;
  logic signed [WIDTH-1:0] op_a_p0;
  logic signed [WIDTH-1:0] op_b_p0;
  logic [1:0]              op_fun_p0;
  logic [1:0]              rsp_code_p1;
  logic                    rsp_err_p1;
  logic                    accept;

`ifdef CMP_ISSUE_CHECK_EN
  logic                    rsp_mismatch_p1;

  // Expected comparator answer for a function code on signed operands.
  function automatic logic [1:0] ref_code(input logic signed [WIDTH-1:0] a,
                                          input logic signed [WIDTH-1:0] b,
                                          input logic [1:0]              fun);
    logic [1:0] r;
    r = 2'd0;
    case (fun)
      2'b01:   r = (a == b) ? 2'd1 : 2'd0;
      2'b10:   r = (a > b)  ? 2'd2 : 2'd0;
      2'b11:   r = (a < b)  ? 2'd3 : 2'd0;
      default: r = 2'd0;
    endcase
    return r;
  endfunction
`endif

  assign accept = (state_q == S_IDLE) && bus.REQ_VALID;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake/strobe outputs; a flag coinciding with the last wait
  // cycle is taken as a real answer rather than a timeout.
  always_comb begin
    state_d        = state_q;
    bus.REQ_READY  = 1'b0;
    bus.CMP_Enable = 1'b0;
    bus.RSP_VALID  = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.REQ_READY = 1'b1;
        if (bus.REQ_VALID) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        bus.CMP_Enable = 1'b1;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        if (bus.CMP_Flag || (wait_cnt == CNT_LAST)) state_d = S_RESP;
      end
      S_RESP: begin
        bus.RSP_VALID = 1'b1;
        if (bus.RSP_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 0: operands held on the comparator inputs from acceptance to the next one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_a_p0   <= '0;
      op_b_p0   <= '0;
      op_fun_p0 <= 2'b00;
    end else if (accept) begin
      op_a_p0   <= bus.REQ_A;
      op_b_p0   <= bus.REQ_B;
      op_fun_p0 <= bus.REQ_FUN;
    end
  end

  // Wait-cycle counter: cleared on issue, saturating while waiting for the flag.
  always_ff @(posedge CLK) begin
    if (RST)                          wait_cnt <= '0;
    else if (state_q == S_ISSUE)      wait_cnt <= '0;
    else if ((state_q == S_WAIT) && !bus.CMP_Flag && (wait_cnt != CNT_SAT))
                                      wait_cnt <= wait_cnt + 1'b1;
  end

  // Stage 1: response capture, only while waiting, so one capture per request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_code_p1 <= 2'd0;
      rsp_err_p1  <= 1'b0;
    end else if (state_q == S_WAIT) begin
      if (bus.CMP_Flag) begin
        rsp_code_p1 <= bus.CMP_OUT;
        rsp_err_p1  <= 1'b0;
      end else if (wait_cnt == CNT_LAST) begin
        rsp_code_p1 <= 2'd0;
        rsp_err_p1  <= 1'b1;
      end
    end
  end

`ifdef CMP_ISSUE_CHECK_EN
  // Mismatch against the local reference; a timeout never reports a mismatch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_mismatch_p1 <= 1'b0;
    end else if (state_q == S_WAIT) begin
      if (bus.CMP_Flag)
        rsp_mismatch_p1 <= (bus.CMP_OUT != ref_code(op_a_p0, op_b_p0, op_fun_p0));
      else if (wait_cnt == CNT_LAST)
        rsp_mismatch_p1 <= 1'b0;
    end
  end

  assign bus.RSP_MISMATCH = rsp_mismatch_p1;
`endif

  assign bus.CMP_A    = op_a_p0;
  assign bus.CMP_B    = op_b_p0;
  assign bus.CMP_FUN  = op_fun_p0;
  assign bus.RSP_CODE = rsp_code_p1;
  assign bus.RSP_ERR  = rsp_err_p1;

endmodule

// File: tb/tb_cmp_issue_ctrl.sv
// Bench for cmp_issue_ctrl: directed requests, a registered comparator model with
// flag injection, and a scoreboard popped by an independent response monitor.
module tb_cmp_issue_ctrl;

  logic CLK;
  logic RST;
  int   cyc;
  int   errors;
  int   checks;

  cmp_issue_ctrl_if #(.WIDTH(16)) bus ();

  cmp_issue_ctrl #(.WIDTH(16), .TIMEOUT(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] code;
    logic       err;
    logic       mm;
  } exp_t;

  exp_t sb[$];

  // comparator model controls
  logic       alive;
  logic [1:0] cmp_resp;
  logic       mdl_flag;
  logic [1:0] mdl_out;
  logic       inj_flag;
  logic [1:0] inj_out;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Registered comparator: answers one cycle after the enable strobe.
  always @(posedge CLK) begin
    mdl_flag <= alive && (bus.CMP_Enable === 1'b1);
    mdl_out  <= cmp_resp;
  end

  assign bus.CMP_Flag = mdl_flag | inj_flag;
  assign bus.CMP_OUT  = inj_flag ? inj_out : mdl_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge CLK) begin
    if (RST === 1'b0 && bus.RSP_VALID === 1'b1 && bus.RSP_READY === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got code=%0h err=%0h expected no response",
                 bus.RSP_CODE, bus.RSP_ERR);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_code", 32'(bus.RSP_CODE), 32'(e.code));
        chk("rsp_err",  32'(bus.RSP_ERR),  32'(e.err));
`ifdef CMP_ISSUE_CHECK_EN
        chk("rsp_mismatch", 32'(bus.RSP_MISMATCH), 32'(e.mm));
`endif
      end
    end
  end

  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic [1:0] fun, input logic [1:0] ecode, input logic eerr,
                      input logic emm, input bit push, output int acc);
    bit ok;
    exp_t e;
    ok = 1'b0;
    @(posedge CLK); #1;
    bus.REQ_VALID = 1'b1;
    bus.REQ_A     = a;
    bus.REQ_B     = b;
    bus.REQ_FUN   = fun;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (bus.REQ_READY === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_accept: got REQ_READY=0 for 40 cycles expected 1");
      bus.REQ_VALID = 1'b0;
      acc = -1;
    end else begin
      @(posedge CLK);
      acc = cyc;
      #1;
      bus.REQ_VALID = 1'b0;
      if (push) begin
        e.code = ecode;
        e.err  = eerr;
        e.mm   = emm;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (bus.RSP_VALID === 1'b1 && bus.RSP_READY === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: got no response in 40 cycles expected one");
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc1;
    int  acc2;
    bit  saw;
    cyc           = 0;
    errors        = 0;
    checks        = 0;
    RST           = 1'b1;
    alive         = 1'b1;
    cmp_resp      = 2'd0;
    inj_flag      = 1'b0;
    inj_out       = 2'd0;
    bus.REQ_VALID = 1'b0;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.REQ_FUN   = 2'b00;
    bus.RSP_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // reset state
    @(negedge CLK);
    chk("rst_req_ready", 32'(bus.REQ_READY), 32'd1);
    chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("rst_cmp_en",    32'(bus.CMP_Enable), 32'd0);
    chk("rst_rsp_code",  32'(bus.RSP_CODE), 32'd0);
    chk("rst_rsp_err",   32'(bus.RSP_ERR), 32'd0);
    chk("rst_cmp_a",     32'(bus.CMP_A), 32'd0);

    // 1: equal, latency N+1 strobe, N+3 response
    cmp_resp = 2'd1;
    send(16'sd5, 16'sd5, 2'b01, 2'd1, 1'b0, 1'b0, 1'b1, acc1);
    @(negedge CLK);
    chk("t1_en_n1",  32'(bus.CMP_Enable), 32'd1);
    chk("t1_cmp_a",  32'(bus.CMP_A), 32'd5);
    chk("t1_cmp_b",  32'(bus.CMP_B), 32'd5);
    chk("t1_cmp_fun", 32'(bus.CMP_FUN), 32'd1);
    chk("t1_rdy_n1", 32'(bus.REQ_READY), 32'd0);
    @(negedge CLK);
    chk("t1_en_n2",  32'(bus.CMP_Enable), 32'd0);
    chk("t1_vld_n2", 32'(bus.RSP_VALID), 32'd0);
    @(negedge CLK);
    chk("t1_vld_n3", 32'(bus.RSP_VALID), 32'd1);
    @(posedge CLK); #1;

    // 2: signed less, then signed greater answered with 0
    cmp_resp = 2'd3;
    send(-16'sd3, 16'sd2, 2'b11, 2'd3, 1'b0, 1'b0, 1'b1, acc1);
    drain();
    cmp_resp = 2'd0;
    send(-16'sd3, 16'sd2, 2'b10, 2'd0, 1'b0, 1'b0, 1'b1, acc1);
    drain();

    // back-to-back throughput: one request every 4 cycles
    cmp_resp = 2'd2;
    send(16'sd100, -16'sd100, 2'b10, 2'd2, 1'b0, 1'b0, 1'b1, acc1);
    send(16'sd9, 16'sd8, 2'b10, 2'd2, 1'b0, 1'b0, 1'b1, acc2);
    chk("b2b_spacing", 32'(acc2 - acc1), 32'd4);
    drain();

    // 3: dead comparator -> timeout 8 cycles after entering WAIT (N+2)
    alive = 1'b0;
    send(16'sd1, 16'sd2, 2'b11, 2'd0, 1'b1, 1'b0, 1'b1, acc1);
    repeat (9) @(negedge CLK);
    chk("t3_vld_n9",  32'(bus.RSP_VALID), 32'd0);
    @(negedge CLK);
    chk("t3_vld_n10", 32'(bus.RSP_VALID), 32'd1);
    @(posedge CLK); #1;

    // flag on the last wait cycle beats the timeout
    send(16'sd4, 16'sd4, 2'b01, 2'd1, 1'b0, 1'b0, 1'b1, acc1);
    repeat (8) @(posedge CLK);
    #1;
    inj_flag = 1'b1;
    inj_out  = 2'd1;
    @(negedge CLK);
    chk("tie_vld_n9", 32'(bus.RSP_VALID), 32'd0);
    @(posedge CLK); #1;
    inj_flag = 1'b0;
    @(negedge CLK);
    chk("tie_vld_n10", 32'(bus.RSP_VALID), 32'd1);
    @(posedge CLK); #1;
    alive = 1'b1;

    // 4: response stall with a pending request and a stray flag in RESP
    cmp_resp      = 2'd2;
    bus.RSP_READY = 1'b0;
    send(16'sd7, 16'sd1, 2'b10, 2'd2, 1'b0, 1'b0, 1'b1, acc1);
    bus.REQ_VALID = 1'b1;
    bus.REQ_A     = -16'sd8;
    bus.REQ_B     = -16'sd9;
    bus.REQ_FUN   = 2'b11;
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("t4_vld_hold",  32'(bus.RSP_VALID), 32'd1);
      chk("t4_code_hold", 32'(bus.RSP_CODE), 32'd2);
      chk("t4_rdy_low",   32'(bus.REQ_READY), 32'd0);
      chk("t4_cmp_a",     32'(bus.CMP_A), 32'd7);
      @(posedge CLK); #1;
      inj_flag = (k == 0);
      inj_out  = 2'd3;
    end
    cmp_resp      = 2'd0;
    bus.RSP_READY = 1'b1;
    send(-16'sd8, -16'sd9, 2'b11, 2'd0, 1'b0, 1'b0, 1'b1, acc1);
    chk("t4_second_a", 32'(bus.CMP_A), 32'(-32'sd8));
    drain();

    // 5: reset while in WAIT aborts; a later flag gives no response
    alive = 1'b0;
    send(16'sd11, 16'sd22, 2'b01, 2'd0, 1'b0, 1'b0, 1'b0, acc1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("t5_req_ready", 32'(bus.REQ_READY), 32'd1);
    chk("t5_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("t5_cmp_en",    32'(bus.CMP_Enable), 32'd0);
    chk("t5_cmp_a",     32'(bus.CMP_A), 32'd0);
    chk("t5_cmp_fun",   32'(bus.CMP_FUN), 32'd0);
    chk("t5_rsp_err",   32'(bus.RSP_ERR), 32'd0);
    @(posedge CLK); #1;
    inj_flag = 1'b1;
    inj_out  = 2'd1;
    @(posedge CLK); #1;
    inj_flag = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (bus.RSP_VALID !== 1'b0) saw = 1'b1;
    end
    chk("t5_no_rsp", 32'(saw), 32'd0);
    alive = 1'b1;

`ifdef CMP_ISSUE_CHECK_EN
    // 6: reference check against the comparator answer
    cmp_resp = 2'd0;
    send(16'sd7, 16'sd1, 2'b10, 2'd0, 1'b0, 1'b1, 1'b1, acc1);
    drain();
    cmp_resp = 2'd2;
    send(16'sd7, 16'sd1, 2'b10, 2'd2, 1'b0, 1'b0, 1'b1, acc1);
    drain();
`endif

    repeat (2) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
